// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice reused NIBBLES times,
// LSB nibble first, with the inter-nibble carry held in a flip-flop.

module nibble_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (ci & (x ^ y));
endmodule

module nibble_serial_adder #(
  parameter int WIDTH   = 16,          // multiple of 4, >= 4
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             ovf
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic             carry_ff;
  logic [CW-1:0]    cnt;
  logic [3:0]       sum4;
  logic [4:0]       c;
  logic             accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(NIBBLES - 1));

  // Shared 4-bit ripple slice
  assign c[0] = carry_ff;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    nibble_fa u_fa (
      .x   (opa[i]),
      .y   (opb[i]),
      .ci  (c[i]),
      .sum (sum4[i]),
      .co  (c[i+1])
    );
  end

  // Sum nibbles enter at the top so the LSB nibble lands at bit 0 after NIBBLES passes
  if (WIDTH == 4) begin : g_res1
    assign res_nxt = sum4;
  end else begin : g_resn
    assign res_nxt = {sum4, res[WIDTH-1:4]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = RUN;
      RUN:     if (last)            state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opa      <= a;
          opb      <= b;
          carry_ff <= cin;
          cnt      <= '0;
        end
        RUN: begin
          res      <= res_nxt;
          opa      <= opa >> 4;
          opb      <= opb >> 4;
          carry_ff <= c[4];
          cnt      <= cnt + CW'(1);
          if (last) begin
            s     <= res_nxt;
            carry <= c[4];
            ovf   <= (opa[3] == opb[3]) && (sum4[3] != opa[3]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) against an integer reference.

module tb_nibble_serial_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         carry, ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .carry(carry), .ovf(ovf)
  );

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rc);
    longint u, sg;
    logic   o;
    u  = longint'(ra) + longint'(rb) + longint'(rc);
    sg = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rc);
    o  = (sg > 32767) || (sg < -32768);
    return {o, u[W], u[W-1:0]};
  endfunction

  // Present operands; returns after the accept edge (+1).
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc);
    @(negedge clk);
    a = ta; b = tb2; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; timeout flagged rather than hanging.
  task automatic wait_valid(output int n, output bit to);
    bit got = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    to = !got;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, s, carry, ovf} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ov=%b ir=%b s=%h c=%b o=%b want 0 1 0000 0 0",
               out_valid, in_ready, s, carry, ovf);
    end
  endtask

  task automatic test_directed(input string nm, input logic [W-1:0] ta,
                               input logic [W-1:0] tb2, input logic tc,
                               input logic [W-1:0] es, input logic ec, input logic eo);
    int n; bit to;
    send(ta, tb2, tc);
    wait_valid(n, to);
    checks++;
    if (to || n != 4) begin
      errors++;
      $display("FAIL %s latency: got %0d (timeout=%b) want 4", nm, n, to);
    end
    checks++;
    if ({s, carry, ovf} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL %s result: s=%h c=%b o=%b want s=%h c=%b o=%b", nm, s, carry, ovf, es, ec, eo);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int n; bit to;
    logic [W+1:0] r;
    bit bad = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    wait_valid(n, to);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || s !== 16'h3333 || carry !== 1'b0 || ovf !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (to || bad) begin
      errors++;
      $display("FAIL backpressure hold: ov=%b ir=%b s=%h want 1 0 3333", out_valid, in_ready, s);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure release: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure accept: in_ready=%b want 0", in_ready);
    end
    wait_valid(n, to);
    r = ref_add(16'h0F0F, 16'h0101, 1'b1);
    checks++;
    if (to || n != 4 || {ovf, carry, s} !== r) begin
      errors++;
      $display("FAIL backpressure queued: n=%0d s=%h c=%b o=%b want n=4 %h", n, s, carry, ovf, r);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    send(16'hAAAA, 16'h5555, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || s !== 16'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid state: ir=%b s=%h ov=%b want 1 0000 0", in_ready, s, out_valid);
    end
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid spurious: out_valid=1 want 0");
    end
    test_directed("after_reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n; bit to;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W+1:0] r;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i % 4 == 0) ra = {1'b0, ra[W-2:0]} | 16'h7000;
      send(ra, rb, rc);
      wait_valid(n, to);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      r = ref_add(ra, rb, rc);
      checks++;
      if (to || n != 4 || {ovf, carry, s} !== r) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] a=%h b=%h cin=%b: n=%0d s=%h c=%b o=%b want %h",
                   i, ra, rb, rc, n, s, carry, ovf, r);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic",   16'h0002, 16'h0006, 1'b0, 16'h0008, 1'b0, 1'b0);
    test_directed("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_directed("ovf_neg", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
